// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  // Round-robin pointer successor: the lane after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr.
// ptr moves past the winner only when a grant is issued.
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          any,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] ptr;
  int            pos;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (en && !any && req[pos]) begin
        grant[pos] = 1'b1;
        any        = 1'b1;
        idx        = PW'(pos);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= PW'(rr_next(int'(idx), N));
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates writeback sources onto the register file's single write port,
// stages the winner for one cycle and forwards the staged write to both read ports.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_hold,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 WE3,
  output logic [AW-1:0]        rd,
  output logic [XLEN-1:0]      WD3,
  input  logic [AW-1:0]        byp_rs1,
  input  logic [AW-1:0]        byp_rs2,
  output logic                 byp1_hit,
  output logic [XLEN-1:0]      byp1_data,
  output logic                 byp2_hit,
  output logic [XLEN-1:0]      byp2_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            grant_en;
  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  // Grants are suppressed while held and while reset is asserted.
  assign grant_en = !wb_hold && !rst;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (grant_en),
    .req   (req_valid),
    .grant (req_ready),
    .any   (grant_any),
    .idx   (grant_idx)
  );

  assign sel_rd   = req_rd[int'(grant_idx)*AW +: AW];
  assign sel_data = req_data[int'(grant_idx)*XLEN +: XLEN];

  // x0 writes still complete the handshake but never assert the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE3 <= 1'b0;
      rd  <= '0;
      WD3 <= '0;
    end else begin
      WE3 <= grant_any && (sel_rd != '0);
      if (grant_any) begin
        rd  <= sel_rd;
        WD3 <= sel_data;
      end
    end
  end

  assign byp1_hit  = WE3 && (rd == byp_rs1) && (byp_rs1 != '0);
  assign byp2_hit  = WE3 && (rd == byp_rs2) && (byp_rs2 != '0);
  assign byp1_data = byp1_hit ? WD3 : '0;
  assign byp2_data = byp2_hit ? WD3 : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of grants and staged writes.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst;
  logic                 wb_hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 WE3;
  logic [AW-1:0]        rd;
  logic [XLEN-1:0]      WD3;
  logic [AW-1:0]        byp_rs1;
  logic [AW-1:0]        byp_rs2;
  logic                 byp1_hit;
  logic [XLEN-1:0]      byp1_data;
  logic                 byp2_hit;
  logic [XLEN-1:0]      byp2_data;

  int checks;
  int errors;

  // Model state: round-robin pointer, staged write, architectural register file.
  int              m_ptr;
  logic            m_we;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_wd;
  logic [XLEN-1:0] m_rf   [32];
  logic [XLEN-1:0] dut_rf [32];
  logic [NREQ-1:0] last_grant;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_hold   (wb_hold),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .WE3       (WE3),
    .rd        (rd),
    .WD3       (WD3),
    .byp_rs1   (byp_rs1),
    .byp_rs2   (byp_rs2),
    .byp1_hit  (byp1_hit),
    .byp1_data (byp1_data),
    .byp2_hit  (byp2_hit),
    .byp2_data (byp2_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic model_reset();
    m_ptr = 0;
    m_we  = 1'b0;
    m_rd  = '0;
    m_wd  = '0;
  endtask

  function automatic logic [NREQ-1:0] exp_grant();
    logic [NREQ-1:0] g;
    g = '0;
    if (rst || wb_hold) return g;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) begin
        g[(m_ptr + k) % NREQ] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic drive(input logic [NREQ-1:0] v, input logic [AW-1:0] r0, input logic [XLEN-1:0] d0,
                       input logic [AW-1:0] r1, input logic [XLEN-1:0] d1, input logic h);
    req_valid = v;
    req_rd    = {r1, r0};
    req_data  = {d1, d0};
    wb_hold   = h;
  endtask

  // Advance one clock: the register file absorbs the current staged write and the
  // model takes the transfer the spec rules say happens on this edge.
  task automatic tick();
    logic [NREQ-1:0] g;
    logic [AW-1:0]   wr_rd;
    @(negedge clk);
    if (WE3 === 1'b1) dut_rf[rd] = WD3;
    g = exp_grant();
    if (m_we) m_rf[m_rd] = m_wd;
    if (rst) begin
      model_reset();
    end else if (g != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          wr_rd = req_rd[i*AW +: AW];
          m_we  = (wr_rd != '0);
          m_rd  = wr_rd;
          m_wd  = req_data[i*XLEN +: XLEN];
          m_ptr = (i + 1) % NREQ;
        end
      end
    end else begin
      m_we = 1'b0;
    end
    last_grant = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0);
    tick();
    tick();
    #2;
    rst     = 1'b1;
    byp_rs1 = 5'd1;
    byp_rs2 = 5'd2;
    #1;
    checks += 5;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", WE3); end
    if (rd !== '0) begin errors++; $display("FAIL reset_rd got %0d want 0", rd); end
    if (WD3 !== '0) begin errors++; $display("FAIL reset_wd got %h want 0", WD3); end
    if (byp1_hit !== 1'b0 || byp2_hit !== 1'b0) begin
      errors++; $display("FAIL reset_byp got %b%b want 00", byp1_hit, byp2_hit);
    end
    model_reset();
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", req_ready); end
    tick();
  endtask

  task automatic test_pair();
    logic [NREQ-1:0] eg;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive(2'b11, 5'd3, 32'hA0, 5'd4, 32'hB1, 1'b0);
      else       drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
      #2;
      eg = exp_grant();
      checks += 2;
      if (req_ready !== eg) begin errors++; $display("FAIL pair_grant c=%0d got %b want %b", c, req_ready, eg); end
      if (WE3 !== m_we || (m_we && rd !== m_rd)) begin
        errors++; $display("FAIL pair_write c=%0d got we=%b rd=%0d want we=%b rd=%0d", c, WE3, rd, m_we, m_rd);
      end
      tick();
    end
  endtask

  task automatic test_x0();
    drive(2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    #2;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL x0_ready got %b want 10", req_ready); end
    tick();
    drive(2'b11, 5'd9, 32'h9, 5'd10, 32'h10, 1'b0);
    #2;
    checks += 2;
    if (WE3 !== 1'b0) begin errors++; $display("FAIL x0_we got %b want 0", WE3); end
    if (req_ready !== 2'b01) begin errors++; $display("FAIL x0_ptr got %b want 01", req_ready); end
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_bypass();
    drive(2'b01, 5'd7, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0);
    #2;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL byp_ready got %b want 01", req_ready); end
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    byp_rs1 = 5'd7;
    byp_rs2 = 5'd0;
    #2;
    checks += 4;
    if (byp1_hit !== 1'b1) begin errors++; $display("FAIL byp1_hit got %b want 1", byp1_hit); end
    if (byp1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL byp1_data got %h want deadbeef", byp1_data); end
    if (byp2_hit !== 1'b0) begin errors++; $display("FAIL byp2_hit got %b want 0", byp2_hit); end
    if (byp2_data !== 32'h0) begin errors++; $display("FAIL byp2_data got %h want 0", byp2_data); end
    tick();
    #2;
    checks++;
    if (byp1_hit !== 1'b0) begin errors++; $display("FAIL byp_stale got %b want 0", byp1_hit); end
    tick();
  endtask

  task automatic test_hold();
    logic [NREQ-1:0] eg;
    drive(2'b11, 5'd12, 32'hC0, 5'd13, 32'hC1, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 5'd12, 32'hC0, 5'd13, 32'hC1, 1'b1);
      #2;
      checks += 3;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL hold_ready c=%0d got %b want 00", c, req_ready); end
      if (WE3 !== m_we) begin errors++; $display("FAIL hold_we c=%0d got %b want %b", c, WE3, m_we); end
      if (rd !== m_rd || WD3 !== m_wd) begin
        errors++; $display("FAIL hold_keep c=%0d got rd=%0d wd=%h want rd=%0d wd=%h", c, rd, WD3, m_rd, m_wd);
      end
      tick();
    end
    drive(2'b11, 5'd12, 32'hC0, 5'd13, 32'hC1, 1'b0);
    #2;
    eg = exp_grant();
    checks++;
    if (req_ready !== eg) begin errors++; $display("FAIL hold_release got %b want %b", req_ready, eg); end
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_same_rd();
    drive(2'b01, 5'd5, 32'd1, 5'd0, 32'h0, 1'b0);
    tick();
    drive(2'b10, 5'd0, 32'h0, 5'd5, 32'd2, 1'b0);
    #2;
    checks++;
    if (WE3 !== 1'b1 || rd !== 5'd5 || WD3 !== 32'd1) begin
      errors++; $display("FAIL same_rd_first got we=%b rd=%0d wd=%0d want 1/5/1", WE3, rd, WD3);
    end
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    #2;
    checks++;
    if (WE3 !== 1'b1 || rd !== 5'd5 || WD3 !== 32'd2) begin
      errors++; $display("FAIL same_rd_second got we=%b rd=%0d wd=%0d want 1/5/2", WE3, rd, WD3);
    end
    tick();
    tick();
    checks++;
    if (dut_rf[5] !== 32'd2) begin errors++; $display("FAIL same_rd_final got %0d want 2", dut_rf[5]); end
  endtask

  task automatic test_random();
    logic            pend [NREQ];
    logic [AW-1:0]   prd  [NREQ];
    logic [XLEN-1:0] pdat [NREQ];
    logic [NREQ-1:0] eg;
    logic            e1, e2;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          prd[i]  = AW'($urandom_range(0, 7));
          pdat[i] = $urandom;
        end
        req_valid[i]            = pend[i];
        req_rd[i*AW +: AW]      = pend[i] ? prd[i] : '0;
        req_data[i*XLEN +: XLEN] = pend[i] ? pdat[i] : '0;
      end
      wb_hold = ($urandom_range(0, 4) == 0);
      byp_rs1 = ($urandom_range(0, 1) == 1) ? m_rd : AW'($urandom_range(0, 7));
      byp_rs2 = AW'($urandom_range(0, 7));
      #2;
      eg = exp_grant();
      e1 = m_we && (m_rd == byp_rs1) && (byp_rs1 != '0);
      e2 = m_we && (m_rd == byp_rs2) && (byp_rs2 != '0);
      checks += 4;
      if (req_ready !== eg) begin errors++; $display("FAIL rand_grant c=%0d got %b want %b", c, req_ready, eg); end
      if (WE3 !== m_we || (m_we && (rd !== m_rd || WD3 !== m_wd))) begin
        errors++; $display("FAIL rand_write c=%0d got %b/%0d/%h want %b/%0d/%h", c, WE3, rd, WD3, m_we, m_rd, m_wd);
      end
      if (byp1_hit !== e1 || byp1_data !== (e1 ? m_wd : '0)) begin
        errors++; $display("FAIL rand_byp1 c=%0d got %b/%h want %b", c, byp1_hit, byp1_data, e1);
      end
      if (byp2_hit !== e2 || byp2_data !== (e2 ? m_wd : '0)) begin
        errors++; $display("FAIL rand_byp2 c=%0d got %b/%h want %b", c, byp2_hit, byp2_data, e2);
      end
      tick();
      for (int i = 0; i < NREQ; i++) if (last_grant[i]) pend[i] = 1'b0;
    end
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();
    tick();
    for (int r = 1; r < 8; r++) begin
      checks++;
      if (dut_rf[r] !== m_rf[r]) begin errors++; $display("FAIL rand_rf x%0d got %h want %h", r, dut_rf[r], m_rf[r]); end
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    wb_hold   = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    byp_rs1   = '0;
    byp_rs2   = '0;
    checks    = 0;
    errors    = 0;
    last_grant = '0;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = '0;
      dut_rf[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_pair();
    test_x0();
    test_bypass();
    test_hold();
    test_same_rd();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
